// File: rtl/rysy_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the rysy_core data bus: 16-byte register
// window, 4-entry TX FIFO, one-cycle registered read data that is 0 when not selected.
module rysy_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               ovf;
  logic [15:0]        baud_div, baud_new, div, baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;

  logic        sel, empty, full, busy, pop, push, baud_tick, irq_nxt;
  logic        wr_txdata, wr_status, wr_baud;
  logic [1:0]  off;
  logic [31:0] status_val, rd_val;

  // Bus decode, FIFO handshake and read mux
  always_comb begin
    sel        = (addr[31:4] == BASE_ADDR[31:4]);
    off        = addr[3:2];
    wr_txdata  = we && sel && (off == 2'd0) && be[0];
    wr_status  = we && sel && (off == 2'd1) && be[0] && wdata[3];
    wr_baud    = we && sel && (off == 2'd2) && (be[0] || be[1]);
    empty      = (count == '0);
    full       = (count == CNT_W'(FIFO_DEPTH));
    busy       = (state != IDLE);
    pop        = (state == IDLE) && !empty;
    push       = wr_txdata && (!full || pop);
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    baud_tick  = (baud_cnt == div - 16'd1);
    baud_new   = {be[1] ? wdata[15:8] : baud_div[15:8], be[0] ? wdata[7:0] : baud_div[7:0]};
    if (baud_new == 16'd0) baud_new = 16'd1;
    // Interrupt tracks the post-edge state so it updates together with state/count
    irq_nxt    = (count_nxt == '0) &&
                 (((state == IDLE) && empty) || ((state == STOP) && baud_tick));
    status_val = {25'b0, 3'(count), ovf, empty, full, busy};
    rd_val     = 32'd0;
    case (off)
      2'd1:    rd_val = status_val;
      2'd2:    rd_val = {16'b0, baud_div};
      default: rd_val = 32'd0;
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers, overflow flag, divisor register and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      baud_div <= CLKS_PER_BIT;
      rdata    <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      if (wr_status) ovf <= 1'b0;
      if (wr_txdata && !push) ovf <= 1'b1;
      if (wr_baud) baud_div <= baud_new;
      rdata <= sel ? rd_val : 32'd0;
    end
  end

  // Transmit FSM; tx and irq are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      irq      <= 1'b1;
      div      <= CLKS_PER_BIT;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      irq <= irq_nxt;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            div      <= baud_div;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            baud_cnt <= 16'd0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_tick) begin
            baud_cnt <= 16'd0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16], be[3:2]};

endmodule
